// File: rtl/gpio_irq_pkg.sv
// Shared register map and priority-encoder helper for the GPIO interrupt controller.
package gpio_irq_pkg;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_RISE    = 2'd1;
  localparam logic [1:0] ADDR_FALL    = 2'd2;
  localparam logic [1:0] ADDR_PENDING = 2'd3;

  localparam int MAX_WIDTH = 16;
  localparam int MAX_ID_W  = 4;

  // Callers zero-extend narrower vectors; bit 0 has the highest priority.
  function automatic logic [MAX_ID_W-1:0] lowest_set_idx(input logic [MAX_WIDTH-1:0] vec);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gpio_irq_sync.sv
// Multi-stage input synchroniser with a one-cycle history register for edge detection.
module gpio_irq_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_out;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO edge interrupt controller: edge capture into W1C pending bits, masked
// lowest-index request to the CPU, and a single-cycle config register port.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(WIDTH)
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  output logic             ext_irq,
  output logic [ID_W-1:0]  irq_id
);

  localparam int WARM_DONE = SYNC_STAGES + 1;
  localparam int WARM_W    = $clog2(WARM_DONE + 1);

  logic [WIDTH-1:0]  rise, fall, hit, clr, act;
  logic [WIDTH-1:0]  enable_q, rise_en_q, fall_en_q, pending_q;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;

  gpio_irq_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .gpio_i  (gpio_i),
    .rise    (rise),
    .fall    (fall)
  );

  // Holds off edge detection until the synchroniser and history register
  // carry real samples, so pins high at reset do not look like rising edges.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)             warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
  end

  assign warm_done = (warm_cnt == WARM_W'(WARM_DONE));
  assign hit       = warm_done ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
  assign clr       = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : '0;
  assign act       = pending_q & enable_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      enable_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pending_q <= '0;
    end else begin
      if (cfg_we && cfg_addr == ADDR_ENABLE) enable_q  <= cfg_wdata;
      if (cfg_we && cfg_addr == ADDR_RISE)   rise_en_q <= cfg_wdata;
      if (cfg_we && cfg_addr == ADDR_FALL)   fall_en_q <= cfg_wdata;
      // New edges win over a simultaneous clear of the same bit.
      pending_q <= (pending_q & ~clr) | hit;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ext_irq <= 1'b0;
      irq_id  <= '0;
    end else begin
      ext_irq <= |act;
      irq_id  <= ID_W'(lowest_set_idx(MAX_WIDTH'(act)));
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = enable_q;
      ADDR_RISE:    cfg_rdata = rise_en_q;
      ADDR_FALL:    cfg_rdata = fall_en_q;
      ADDR_PENDING: cfg_rdata = pending_q;
      default:      cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a sample-history reference model.
module tb_gpio_irq_ctrl;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int ID_W = $clog2(W);

  logic            sys_clk = 1'b0;
  logic            rst;
  logic [W-1:0]    gpio_i;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [W-1:0]    cfg_wdata;
  logic [W-1:0]    cfg_rdata;
  logic            ext_irq;
  logic [ID_W-1:0] irq_id;

  int n_checks = 0;
  int n_errors = 0;

  gpio_irq_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .gpio_i    (gpio_i),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .ext_irq   (ext_irq),
    .irq_id    (irq_id)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state: registers, outputs, and the last S+1 input samples.
  logic [W-1:0]    m_en, m_rise, m_fall, m_pend;
  logic            m_irq;
  logic [ID_W-1:0] m_id;
  int              m_edges;
  logic [W-1:0]    m_hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    m_irq = 1'b0; m_id = '0; m_edges = 0;
    m_hist = {};
    repeat (S + 1) m_hist.push_back('0);
  endtask

  // One clock edge of the model, evaluated on the inputs about to be sampled.
  task automatic model_step();
    logic [W-1:0] s, p, hit, act, clr;
    p = m_hist[0];
    s = m_hist[1];
    hit = '0;
    if (m_edges >= S + 1) hit = (s & ~p & m_rise) | (~s & p & m_fall);
    act = m_pend & m_en;
    m_irq = (act != 0);
    m_id = '0;
    for (int i = W - 1; i >= 0; i--) if (act[i]) m_id = ID_W'(i);
    clr = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : '0;
    if (cfg_we && cfg_addr == 2'd0) m_en   = cfg_wdata;
    if (cfg_we && cfg_addr == 2'd1) m_rise = cfg_wdata;
    if (cfg_we && cfg_addr == 2'd2) m_fall = cfg_wdata;
    m_pend = (m_pend & ~clr) | hit;
    m_hist.push_back(gpio_i);
    void'(m_hist.pop_front());
    if (m_edges < 1000) m_edges++;
  endtask

  function automatic logic [W-1:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_en;
      2'd1:    return m_rise;
      2'd2:    return m_fall;
      default: return m_pend;
    endcase
  endfunction

  task automatic compare_all();
    check("ext_irq", ext_irq, m_irq);
    check("irq_id", irq_id, m_id);
    check("cfg_rdata", cfg_rdata, model_rd(cfg_addr));
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset(input logic [W-1:0] pins);
    gpio_i = pins;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_ext_irq", ext_irq, 0);
    check("rst_irq_id", irq_id, 0);
    check("rst_rdata", cfg_rdata, 0);
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic random_traffic(input int cycles);
    repeat (cycles) begin
      gpio_i   = gpio_i ^ W'($urandom & $urandom & $urandom);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_wdata = W'($urandom);
      tick();
      cfg_we = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; gpio_i = '1; cfg_we = 1'b0; cfg_addr = 2'd3; cfg_wdata = '0;
    model_reset();
    @(negedge sys_clk);

    // Pins high through reset must not produce rising edges after release.
    do_reset('1);
    repeat (10) tick();
    check("warm_pending", cfg_rdata, 8'h00);
    check("warm_ext_irq", ext_irq, 0);

    // Rising edge on pin 2: latency to PENDING and to ext_irq.
    gpio_i = '0;
    repeat (4) tick();
    wr(2'd0, 8'h04);
    wr(2'd1, 8'h04);
    cfg_addr = 2'd3;
    gpio_i[2] = 1'b1;
    tick();
    tick();
    check("lat_pend_n1", cfg_rdata, 8'h00);
    tick();
    check("lat_pend_n2", cfg_rdata, 8'h04);
    check("lat_irq_n2", ext_irq, 0);
    tick();
    check("lat_irq_n3", ext_irq, 1);
    check("lat_id_n3", irq_id, 2);

    // W1C empties PENDING next cycle, ext_irq follows one cycle later.
    wr(2'd3, 8'h04);
    check("w1c_pend", cfg_rdata, 8'h00);
    check("w1c_irq_hold", ext_irq, 1);
    tick();
    check("w1c_irq_drop", ext_irq, 0);

    // New edge coincident with the clear of the same bit keeps it set.
    gpio_i[2] = 1'b0;
    repeat (4) tick();
    gpio_i[2] = 1'b1;
    repeat (4) tick();
    check("pre_race_pend", cfg_rdata, 8'h04);
    gpio_i[2] = 1'b0;
    repeat (4) tick();
    gpio_i[2] = 1'b1;
    tick();
    tick();
    wr(2'd3, 8'h04);
    check("race_pend", cfg_rdata, 8'h04);
    check("race_irq", ext_irq, 1);
    tick();
    check("race_irq_next", ext_irq, 1);

    // Two simultaneous falling edges: priority and re-encode after partial clear.
    gpio_i[5:4] = 2'b11;
    repeat (4) tick();
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h30);
    wr(2'd3, 8'hFF);
    tick();
    tick();
    check("fall_pre_pend", cfg_rdata, 8'h00);
    check("fall_pre_irq", ext_irq, 0);
    gpio_i[5:4] = 2'b00;
    repeat (4) tick();
    check("fall_pend", cfg_rdata, 8'h30);
    check("fall_irq", ext_irq, 1);
    check("fall_id4", irq_id, 4);
    wr(2'd3, 8'h10);
    check("fall_pend_after", cfg_rdata, 8'h20);
    tick();
    check("fall_id5", irq_id, 5);

    // Edges latch while masked; enabling later raises the request.
    wr(2'd0, 8'h00);
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h80);
    wr(2'd3, 8'hFF);
    gpio_i[7] = 1'b1;
    repeat (4) tick();
    check("mask_pend", cfg_rdata, 8'h80);
    check("mask_irq", ext_irq, 0);
    wr(2'd0, 8'h80);
    check("unmask_irq_w", ext_irq, 0);
    tick();
    check("unmask_irq", ext_irq, 1);
    check("unmask_id", irq_id, 7);

    // Random traffic with everything enabled.
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'hA5);
    wr(2'd2, 8'h5A);
    random_traffic(400);

    // Reset mid-operation: cleared, and silent through warm-up.
    do_reset(W'($urandom));
    for (int i = 0; i < S + 2; i++) begin
      tick();
      check("rewarm_irq", ext_irq, 0);
    end
    random_traffic(300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- Interrupt controller between the board GPIO inputs and the CPU's external-interrupt line, replacing the tied-off ext_irq.
- Synchronises gpio_i and detects per-pin rising and/or falling edges.
- Latches detected edges into a pending register and drives a registered ext_irq with the lowest-index active source ID.
- Configured and serviced by firmware through a small single-cycle register port; pending bits are write-1-to-clear.

Parameters:
- WIDTH, 8, number of GPIO interrupt sources (2..16).
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2).
- ID_W, $clog2(WIDTH), width of irq_id (derived; not overridden).

Ports:
- sys_clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- gpio_i  in  WIDTH  raw asynchronous GPIO inputs.
- cfg_we  in  1  register write strobe; one write per cycle.
- cfg_addr  in  2  register select: 0 ENABLE, 1 RISE_EN, 2 FALL_EN, 3 PENDING.
- cfg_wdata  in  WIDTH  write data.
- cfg_rdata  out  WIDTH  combinational read of the register at cfg_addr.
- ext_irq  out  1  registered interrupt request to the CPU.
- irq_id  out  ID_W  registered index of the lowest-numbered pending & enabled source.

Behaviour:
- Reset: all of the following clear to 0 immediately on rst, independent of sys_clk:
  - synchroniser chain, prev-sample register, ENABLE, RISE_EN, FALL_EN, PENDING;
  - ext_irq, irq_id;
  - warm-up counter.
- Warm-up: a counter runs from 0 to SYNC_STAGES+1 after rst deasserts.
  - Edge detection is inhibited while the counter is below SYNC_STAGES+1.
  - Pins already high at reset therefore do not raise false rising edges.
  - The counter saturates and has no effect afterwards.
- Edge detect:
  - s = synchroniser output; p = s delayed one cycle.
  - rise = s & ~p; fall = ~s & p.
  - hit = (rise & RISE_EN) | (fall & FALL_EN), gated by warm-up done.
- PENDING update each cycle: PENDING_next = (PENDING & ~clr) | hit.
  - clr = cfg_wdata when cfg_we and cfg_addr==3, else 0.
  - Set wins over clear in the same cycle on the same bit.
- Edges are latched into PENDING regardless of ENABLE.
  - ENABLE masks only the request output.
  - Enabling a source that is already pending raises ext_irq.
- Config writes:
  - Addresses 0..2: full-width overwrite, effective next cycle.
  - Address 3: W1C per bit; zero bits are left unchanged.
- Read: cfg_rdata = selected register value (PENDING raw, unmasked).
- Output, registered:
  - act = PENDING & ENABLE.
  - ext_irq <= |act.
  - irq_id <= index of lowest set bit of act, or 0 when act is 0.
- Latency: an input transition sampled at edge N sets PENDING at edge N+SYNC_STAGES and asserts ext_irq at edge N+SYNC_STAGES+1 (3 cycles at the default).
- After a W1C that empties act, ext_irq drops one cycle after the PENDING update.
- Glitch rule: a pulse shorter than one sys_clk period may be missed; this is documented, not an error.
- An input toggling rise-then-fall within two cycles sets the bit once; PENDING does not count edges.
- Reset mid-operation: everything is cleared and warm-up restarts; no interrupt is asserted until warm-up completes and a new edge occurs.

Decomposition:
- Package gpio_irq_pkg holds:
  - register address constants ADDR_ENABLE=0, ADDR_RISE=1, ADDR_FALL=2, ADDR_PENDING=3;
  - a function lowest_set_idx for the priority encoder.
- One sub-module, gpio_irq_sync: a WIDTH-wide SYNC_STAGES synchroniser plus prev register, outputting rise/fall vectors.
- Warm-up counter, PENDING register, config block and output register stay in the top module.

Test Plan:
- Reset with gpio_i=8'hFF held high; release rst; wait 10 cycles -> PENDING=0, ext_irq=0 (warm-up suppression).
- Write ENABLE=8'h04, RISE_EN=8'h04; gpio_i[2] 0->1 sampled at edge N -> PENDING=8'h04 at N+2, ext_irq=1 and irq_id=2 at N+3.
- With PENDING=8'h04, write PENDING=8'h04 (W1C) -> PENDING=0 next cycle, ext_irq=0 the cycle after.
- Edge on pin 2 in the same cycle as a W1C of bit 2 -> PENDING bit 2 remains 1 and ext_irq stays 1.
- ENABLE=8'hFF, RISE_EN=0, FALL_EN=8'h30; pins 4 and 5 fall in the same cycle -> PENDING=8'h30, irq_id=4; W1C 8'h10 -> irq_id=5.
- ENABLE=0, rising edge on pin 7 -> PENDING=8'h80, ext_irq=0; then write ENABLE=8'h80 -> ext_irq=1, irq_id=7 two cycles after the write.
